alu_share_arbiter: RTL

- Shares one `ALU_32bit` instance between N_REQ requesters using a round-robin grant.
- Each requester issues one operation (a, b, op) with a valid/ready handshake and receives a registered result with its own valid/ready handshake.
- One operation is in flight at a time.
- Sits between the execute-stage clients (main issue port, address-calc unit, debug port) and the shared ALU.

---
 rtl/alu_share_arbiter_pkg.sv | 25 ++
 rtl/ALU_32bit.sv | 40 ++++
 rtl/alu_share_arbiter_rr_pick.sv | 34 +++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode encodings, FSM states
// and the legal-opcode helper used when capturing a response.
package alu_share_arbiter_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU_32bit.sv
// Shared 32-bit ALU. Overflow is the add-path or sub-path signed overflow
// regardless of opcode; callers mask it to the arithmetic operations.
module ALU_32bit
    import alu_share_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;

    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_add_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
    assign w_sub_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);

    always_comb begin
        result = 32'd0;
        case (alu_control)
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            OP_ADD:  result = w_sum;
            OP_SUB:  result = w_diff;
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            OP_NOR:  result = ~(a | b);
            default: result = 32'd0;
        endcase
    end

    assign zero     = (result == 32'd0);
    assign overflow = (alu_control == OP_SUB) ? w_sub_ovf : w_add_ovf;

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning cyclically upward from the
// pointer, returned as one-hot grant, binary index and an any-request flag.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Walk from farthest to nearest so the candidate closest to the pointer wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == j && i_req[i]) begin
                    o_gnt    = '0;
                    o_gnt[i] = 1'b1;
                    o_idx    = ID_W'(i);
                    o_any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU_32bit between N_REQ requesters with a round-robin grant;
// one operation in flight, result returned through a registered response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [N_REQ-1:0]    req_valid_in,
    output logic [N_REQ-1:0]    req_ready_out,
    input  logic [32*N_REQ-1:0] req_a_in,
    input  logic [32*N_REQ-1:0] req_b_in,
    input  logic [4*N_REQ-1:0]  req_op_in,
    output logic [N_REQ-1:0]    rsp_valid_out,
    input  logic [N_REQ-1:0]    rsp_ready_in,
    output logic [31:0]         rsp_result_out,
    output logic                rsp_zero_out,
    output logic                rsp_overflow_out,
    output logic                rsp_error_out,
    output logic [ID_W-1:0]     grant_id_out,
    output logic                busy_out
);

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [3:0]        r_op;
    logic [31:0]       r_result;
    logic              r_zero;
    logic              r_ovf;
    logic              r_err;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic [31:0]       w_a_sel;
    logic [31:0]       w_b_sel;
    logic [3:0]        w_op_sel;
    logic [31:0]       w_alu_res;
    logic              w_alu_zero;
    logic              w_alu_ovf;
    logic              w_own_ready;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req (req_valid_in),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    ALU_32bit u_alu (
        .a           (r_a),
        .b           (r_b),
        .alu_control (r_op),
        .result      (w_alu_res),
        .zero        (w_alu_zero),
        .overflow    (w_alu_ovf)
    );

    // One-hot AND-OR mux of the granted requester's operands.
    always_comb begin
        w_a_sel  = '0;
        w_b_sel  = '0;
        w_op_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_a_sel  = w_a_sel  | ({32{w_gnt[i]}} & req_a_in[32*i +: 32]);
            w_b_sel  = w_b_sel  | ({32{w_gnt[i]}} & req_b_in[32*i +: 32]);
            w_op_sel = w_op_sel | ({4{w_gnt[i]}}  & req_op_in[4*i +: 4]);
        end
    end

    always_comb begin
        rsp_valid_out = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_out[i] = (r_state == S_RESP) && (r_grant == ID_W'(i));
        end
    end

    assign w_own_ready   = |(rsp_valid_out & rsp_ready_in);
    assign req_ready_out = (r_state == S_IDLE && rst_n_in) ? w_gnt : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a_sel;
                        r_b     <= w_b_sel;
                        r_op    <= w_op_sel;
                        r_grant <= w_idx;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_legal(r_op)) begin
                        r_result <= w_alu_res;
                        r_zero   <= w_alu_zero;
                        r_ovf    <= w_alu_ovf && (r_op == OP_ADD || r_op == OP_SUB);
                        r_err    <= 1'b0;
                    end else begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_own_ready) begin
                        r_rr_ptr <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + ID_W'(1);
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_result_out   = r_result;
    assign rsp_zero_out     = r_zero;
    assign rsp_overflow_out = r_ovf;
    assign rsp_error_out    = r_err;
    assign grant_id_out     = r_grant;
    assign busy_out         = (r_state != S_IDLE);

endmodule
